// File: rtl/cfg_reg_bank_if.sv
// cfg_reg_bank_if: control-FSM to register-bank bus, including the exported register image
interface cfg_reg_bank_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int MEM_WIDTH  = 8,
  parameter int NUM_EXPORT = 4
);
  logic                            WrEn;
  logic                            RdEn;
  logic [ADDR_WIDTH-1:0]           Address;
  logic [MEM_WIDTH-1:0]            WrData;
  logic [MEM_WIDTH-1:0]            WrMask;
  logic                            Lock_In;
  logic [MEM_WIDTH-1:0]            RdData;
  logic                            RdData_Valid;
  logic                            Wr_Ack;
  logic                            Err;
  logic [NUM_EXPORT*MEM_WIDTH-1:0] REG_EXPORT;
  modport master (
    output WrEn, RdEn, Address, WrData, WrMask, Lock_In,
    input  RdData, RdData_Valid, Wr_Ack, Err, REG_EXPORT
  );
  modport slave (
    input  WrEn, RdEn, Address, WrData, WrMask, Lock_In,
    output RdData, RdData_Valid, Wr_Ack, Err, REG_EXPORT
  );
endinterface

// File: rtl/cfg_reg_bank.sv
// cfg_reg_bank: masked-write, lockable register bank with pipelined reads and exported registers
module cfg_reg_bank #(
  parameter int ADDR_WIDTH = 4,
  parameter int MEM_DEPTH  = 16,
  parameter int MEM_WIDTH  = 8,
  parameter int NUM_EXPORT = 4,
  parameter int RD_LATENCY = 1,
  parameter logic [MEM_DEPTH*MEM_WIDTH-1:0] INIT_VAL = (MEM_DEPTH*MEM_WIDTH)'(32'h2081_0000),
  parameter logic [MEM_DEPTH-1:0] LOCK_MASK = MEM_DEPTH'(16'h000C)
) (
  input logic          CLK,
  input logic          RST,
  cfg_reg_bank_if.slave bus
);
  localparam logic [2**ADDR_WIDTH-1:0] LOCK_EXT = (2**ADDR_WIDTH)'(LOCK_MASK);
  logic [MEM_WIDTH-1:0] mem_q [MEM_DEPTH];
  logic [MEM_WIDTH-1:0] pd_q [RD_LATENCY];
  logic [RD_LATENCY-1:0] pv_q;
  logic ack_q, err_q;
  logic wr_req, rd_req, in_range, locked, ack_d, err_d;
  logic [MEM_WIDTH-1:0] rd_word;
  always_comb begin
    wr_req   = bus.WrEn & ~bus.RdEn;
    rd_req   = bus.RdEn & ~bus.WrEn;
    in_range = {1'b0, bus.Address} < (ADDR_WIDTH+1)'(MEM_DEPTH);
    locked   = bus.Lock_In & LOCK_EXT[bus.Address];
    ack_d    = wr_req & in_range & ~locked;
    err_d    = (bus.WrEn & bus.RdEn) | (wr_req & ~ack_d) | (rd_req & ~in_range);
    rd_word  = in_range ? mem_q[bus.Address] : '0;
  end
  // each read stage only loads on a valid beat, so the last stage holds the previous read result
  always_ff @(posedge CLK)
    if (RST) begin
      for (int i = 0; i < MEM_DEPTH; i++) mem_q[i] <= INIT_VAL[i*MEM_WIDTH +: MEM_WIDTH];
      for (int k = 0; k < RD_LATENCY; k++) pd_q[k] <= '0;
      pv_q  <= '0;
      ack_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      for (int i = 0; i < MEM_DEPTH; i++)
        if (ack_d && bus.Address == ADDR_WIDTH'(i))
          mem_q[i] <= (mem_q[i] & ~bus.WrMask) | (bus.WrData & bus.WrMask);
      pv_q[0] <= rd_req;
      pd_q[0] <= rd_req ? rd_word : pd_q[0];
      for (int k = 1; k < RD_LATENCY; k++) begin
        pv_q[k] <= pv_q[k-1];
        pd_q[k] <= pv_q[k-1] ? pd_q[k-1] : pd_q[k];
      end
      ack_q <= ack_d;
      err_q <= err_d;
    end
  always_comb
    for (int i = 0; i < NUM_EXPORT; i++) bus.REG_EXPORT[i*MEM_WIDTH +: MEM_WIDTH] = mem_q[i];
  assign bus.RdData       = pd_q[RD_LATENCY-1];
  assign bus.RdData_Valid = pv_q[RD_LATENCY-1];
  assign bus.Wr_Ack       = ack_q;
  assign bus.Err          = err_q;
endmodule

// File: tb/tb_cfg_reg_bank.sv
// tb_cfg_reg_bank: scoreboard bench driving four banks (read latency 1..4) with identical directed stimulus
module tb_cfg_reg_bank;
  localparam int AW = 4, D = 12, W = 8, NE = 4;
  logic CLK = 1'b0, RST = 1'b1;
  logic wr_en = 1'b0, rd_en = 1'b0, lock = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [W-1:0] wdata = '0, wmask = '0;
  wire rdv [4];
  wire ack [4];
  wire errs [4];
  wire [W-1:0] rdd [4];
  wire [NE*W-1:0] rexp [4];
  always #5 CLK = ~CLK;
  genvar l;
  generate
    for (l = 0; l < 4; l++) begin : g
      cfg_reg_bank_if #(.ADDR_WIDTH(AW), .MEM_WIDTH(W), .NUM_EXPORT(NE)) bus ();
      assign bus.WrEn    = wr_en;
      assign bus.RdEn    = rd_en;
      assign bus.Address = addr;
      assign bus.WrData  = wdata;
      assign bus.WrMask  = wmask;
      assign bus.Lock_In = lock;
      assign rdv[l]  = bus.RdData_Valid;
      assign ack[l]  = bus.Wr_Ack;
      assign errs[l] = bus.Err;
      assign rdd[l]  = bus.RdData;
      assign rexp[l] = bus.REG_EXPORT;
      cfg_reg_bank #(.ADDR_WIDTH(AW), .MEM_DEPTH(D), .MEM_WIDTH(W), .NUM_EXPORT(NE), .RD_LATENCY(l+1))
        dut (.CLK(CLK), .RST(RST), .bus(bus.slave));
    end
  endgenerate
  typedef struct { int i; logic [W-1:0] d; } rd_t;
  typedef struct { int c; bit e; } rs_t;
  rd_t rd_q[$];
  rs_t rs_q[$];
  int rst_q[$];
  int rd_idx[4] = '{0, 0, 0, 0};
  int rs_idx[4] = '{0, 0, 0, 0};
  int n_chk = 0, n_fail = 0, cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  // a read issued at drive cycle i is lost if a reset edge lands before its result registers
  function automatic bit killed(int i, int lat);
    foreach (rst_q[k]) if (rst_q[k] >= i + 1 && rst_q[k] <= i + lat - 1) return 1'b1;
    return 1'b0;
  endfunction
  always @(negedge CLK)
    for (int m = 0; m < 4; m++) begin
      if (rdv[m]) begin
        while (rd_idx[m] < rd_q.size() && killed(rd_q[rd_idx[m]].i, m + 1)) rd_idx[m]++;
        if (rd_idx[m] >= rd_q.size()) begin
          n_chk++;
          n_fail++;
          $display("FAIL L%0d unexpected_valid: got 1 required 0 (cycle %0d)", m + 1, cyc);
        end else begin
          chk($sformatf("L%0d rd_latency", m + 1), cyc, rd_q[rd_idx[m]].i + m + 1);
          chk($sformatf("L%0d rd_data", m + 1), rdd[m], rd_q[rd_idx[m]].d);
          rd_idx[m]++;
        end
      end
      if (ack[m] || errs[m]) begin
        if (rs_idx[m] >= rs_q.size()) begin
          n_chk++;
          n_fail++;
          $display("FAIL L%0d unexpected_rsp: got ack=%0b err=%0b required none (cycle %0d)", m + 1, ack[m], errs[m], cyc);
        end else begin
          chk($sformatf("L%0d rsp_cycle", m + 1), cyc, rs_q[rs_idx[m]].c);
          chk($sformatf("L%0d rsp_ack_err", m + 1), {ack[m], errs[m]}, {!rs_q[rs_idx[m]].e, rs_q[rs_idx[m]].e});
          rs_idx[m]++;
        end
      end
    end
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask
  task automatic wr(input logic [AW-1:0] a, input logic [W-1:0] d, input logic [W-1:0] msk, input bit ok);
    wr_en = 1'b1; addr = a; wdata = d; wmask = msk;
    rs_q.push_back('{cyc + 1, !ok});
    tick();
    wr_en = 1'b0;
  endtask
  task automatic rd(input logic [AW-1:0] a, input logic [W-1:0] d, input bit oor);
    rd_en = 1'b1; addr = a;
    rd_q.push_back('{cyc, d});
    if (oor) rs_q.push_back('{cyc + 1, 1'b1});
    tick();
    rd_en = 1'b0;
  endtask
  task automatic both(input logic [AW-1:0] a);
    wr_en = 1'b1; rd_en = 1'b1; addr = a; wdata = 8'h5A; wmask = 8'hFF;
    rs_q.push_back('{cyc + 1, 1'b1});
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
  endtask
  task automatic do_reset();
    RST = 1'b1;
    rst_q.push_back(cyc);
    tick();
    RST = 1'b0;
  endtask
  task automatic exp_chk(string name, logic [NE*W-1:0] v);
    for (int m = 0; m < 4; m++) chk($sformatf("L%0d %s", m + 1, name), rexp[m], v);
  endtask
  initial begin
    rst_q.push_back(0);
    tick();
    tick();
    RST = 1'b0;
    exp_chk("reset_export", 32'h2081_0000);
    for (int m = 0; m < 4; m++)
      chk($sformatf("L%0d reset_flags", m + 1), {rdv[m], errs[m], ack[m]}, 3'b000);
    wr(0, 8'hFF, 8'h0F, 1);
    exp_chk("masked_write", 32'h2081_000F);
    rd(0, 8'h0F, 0);
    repeat (5) tick();
    lock = 1'b1;
    wr(2, 8'hAA, 8'hFF, 0);
    exp_chk("locked_write", 32'h2081_000F);
    wr(1, 8'h55, 8'hFF, 1);
    exp_chk("lock_unmasked_reg", 32'h2081_550F);
    lock = 1'b0;
    wr(2, 8'hAA, 8'hFF, 1);
    exp_chk("unlocked_write", 32'h20AA_550F);
    wr(3, 8'h00, 8'h00, 1);
    exp_chk("zero_mask", 32'h20AA_550F);
    rd(2, 8'hAA, 0);
    repeat (5) tick();
    both(0);
    exp_chk("both_reject", 32'h20AA_550F);
    wr(13, 8'h11, 8'hFF, 0);
    rd(15, 8'h00, 1);
    rd(11, 8'h00, 0);
    wr(11, 8'h3C, 8'hFF, 1);
    rd(11, 8'h3C, 0);
    repeat (6) tick();
    rd(0, 8'h0F, 0);
    rd(1, 8'h55, 0);
    rd(2, 8'hAA, 0);
    rd(3, 8'h20, 0);
    repeat (6) tick();
    rd(0, 8'h0F, 0);
    rd(1, 8'h55, 0);
    rd(2, 8'hAA, 0);
    do_reset();
    repeat (6) tick();
    exp_chk("mid_read_reset", 32'h2081_0000);
    rd(11, 8'h00, 0);
    rd(2, 8'h81, 0);
    repeat (8) tick();
    for (int m = 0; m < 4; m++) begin
      while (rd_idx[m] < rd_q.size() && killed(rd_q[rd_idx[m]].i, m + 1)) rd_idx[m]++;
      chk($sformatf("L%0d reads_delivered", m + 1), rd_idx[m], rd_q.size());
      chk($sformatf("L%0d rsps_delivered", m + 1), rs_idx[m], rs_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
